// File: rtl/cdb_arb.sv
// Common data bus arbiter: grants up to four completed FUs per cycle.
// Define CDB_ARB_RR_EN for round-robin priority; otherwise FU0 is highest.
`ifndef CDB_WIDTH
`define CDB_WIDTH 4
`endif

module cdb_arb (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  recover,
    input  logic [7:0]            fu_req,
    input  logic [55:0]           fu_pr_tags,
    input  logic [39:0]           fu_ar_tags,
    output logic [7:0]            fu_grant,
    output logic [`CDB_WIDTH-1:0] cdb_broadcast,
    output logic [6:0]            cdb_pr_tag0,
    output logic [6:0]            cdb_pr_tag1,
    output logic [6:0]            cdb_pr_tag2,
    output logic [6:0]            cdb_pr_tag3,
    output logic [4:0]            cdb_ar_tag0,
    output logic [4:0]            cdb_ar_tag1,
    output logic [4:0]            cdb_ar_tag2,
    output logic [4:0]            cdb_ar_tag3
);

    logic [2:0]            rr_ptr;
    logic [2:0]            gcnt;
    logic [2:0]            idx;
    logic [2:0]            slot_fu [4];
    logic [`CDB_WIDTH-1:0] bcast_mask;
    logic [6:0]            pr_in [8];
    logic [4:0]            ar_in [8];
    logic [6:0]            pr_q [4];
    logic [4:0]            ar_q [4];
`ifdef CDB_ARB_RR_EN
    logic [2:0]            last_idx;
    logic [2:0]            rr_nxt;
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pr_in[i] = fu_pr_tags[7*i +: 7];
            ar_in[i] = fu_ar_tags[5*i +: 5];
        end
    end

    // Scan from rr_ptr with wrap; the k-th winner lands in slot k.
    always_comb begin
        fu_grant = '0;
        gcnt     = '0;
        idx      = '0;
        for (int k = 0; k < 4; k++) slot_fu[k] = '0;
`ifdef CDB_ARB_RR_EN
        last_idx = rr_ptr;
`endif
        if (!reset && !recover) begin
            for (int i = 0; i < 8; i++) begin
                idx = rr_ptr + 3'(i);
                if (fu_req[idx] && gcnt < 3'd4) begin
                    fu_grant[idx]        = 1'b1;
                    slot_fu[gcnt[1:0]]   = idx;
                    gcnt                 = gcnt + 3'd1;
`ifdef CDB_ARB_RR_EN
                    last_idx             = idx;
`endif
                end
            end
        end
    end

    always_comb begin
        case (gcnt)
            3'd0:    bcast_mask = 4'b0000;
            3'd1:    bcast_mask = 4'b0001;
            3'd2:    bcast_mask = 4'b0011;
            3'd3:    bcast_mask = 4'b0111;
            default: bcast_mask = 4'b1111;
        endcase
    end

`ifdef CDB_ARB_RR_EN
    assign rr_nxt = (gcnt != 3'd0) ? last_idx + 3'd1 : rr_ptr;

    always_ff @(posedge clock) begin
        if (reset) rr_ptr <= '0;
        else       rr_ptr <= rr_nxt;
    end
`else
    assign rr_ptr = 3'd0;
`endif

    // Recover yields zero grants, so mask and tags clear naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_broadcast <= '0;
            for (int k = 0; k < 4; k++) begin
                pr_q[k] <= '0;
                ar_q[k] <= '0;
            end
        end else begin
            cdb_broadcast <= bcast_mask;
            for (int k = 0; k < 4; k++) begin
                pr_q[k] <= bcast_mask[k] ? pr_in[slot_fu[k]] : 7'd0;
                ar_q[k] <= bcast_mask[k] ? ar_in[slot_fu[k]] : 5'd0;
            end
        end
    end

    assign cdb_pr_tag0 = pr_q[0];
    assign cdb_pr_tag1 = pr_q[1];
    assign cdb_pr_tag2 = pr_q[2];
    assign cdb_pr_tag3 = pr_q[3];
    assign cdb_ar_tag0 = ar_q[0];
    assign cdb_ar_tag1 = ar_q[1];
    assign cdb_ar_tag2 = ar_q[2];
    assign cdb_ar_tag3 = ar_q[3];

endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb; expectations follow CDB_ARB_RR_EN if defined.
`timescale 1ns/1ps

module tb_cdb_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        recover;
    logic [7:0]  fu_req;
    logic [55:0] fu_pr_tags;
    logic [39:0] fu_ar_tags;
    logic [7:0]  fu_grant;
    logic [3:0]  cdb_broadcast;
    logic [6:0]  pr_o [4];
    logic [4:0]  ar_o [4];

    int n_chk  = 0;
    int n_fail = 0;

`ifdef CDB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    cdb_arb dut (
        .clock         (clock),
        .reset         (reset),
        .recover       (recover),
        .fu_req        (fu_req),
        .fu_pr_tags    (fu_pr_tags),
        .fu_ar_tags    (fu_ar_tags),
        .fu_grant      (fu_grant),
        .cdb_broadcast (cdb_broadcast),
        .cdb_pr_tag0   (pr_o[0]),
        .cdb_pr_tag1   (pr_o[1]),
        .cdb_pr_tag2   (pr_o[2]),
        .cdb_pr_tag3   (pr_o[3]),
        .cdb_ar_tag0   (ar_o[0]),
        .cdb_ar_tag1   (ar_o[1]),
        .cdb_ar_tag2   (ar_o[2]),
        .cdb_ar_tag3   (ar_o[3])
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_tags;
        for (int i = 0; i < 8; i++) begin
            fu_pr_tags[7*i +: 7] = 7'(100 + i);
            fu_ar_tags[5*i +: 5] = 5'(20 + i);
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        recover = 1'b0;
        fu_req  = 8'hFF;
        set_tags();
        tick();
        tick();
        n_chk++;
        if (fu_grant !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_grant got %b want 00000000", fu_grant);
        end
        n_chk++;
        if (cdb_broadcast !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_bcast got %b want 0000", cdb_broadcast);
        end
        n_chk++;
        if (dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_rr got %0d want 0", dut.rr_ptr);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (pr_o[k] !== 7'd0 || ar_o[k] !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_tag%0d got %0d/%0d want 0/0",
                         k, pr_o[k], ar_o[k]);
            end
        end
        reset  = 1'b0;
        fu_req = 8'h00;
        tick();
    endtask

    task automatic test_basic;
        logic [6:0] epr [4];
        logic [4:0] ear [4];
        epr = '{7'd33, 7'd40, 7'd0, 7'd0};
        ear = '{5'd11, 5'd12, 5'd0, 5'd0};
        fu_pr_tags[7 +: 7]  = 7'd33;
        fu_pr_tags[14 +: 7] = 7'd40;
        fu_ar_tags[5 +: 5]  = 5'd11;
        fu_ar_tags[10 +: 5] = 5'd12;
        fu_req = 8'b0000_0110;
        #1;
        n_chk++;
        if (fu_grant !== 8'b0000_0110) begin
            n_fail++;
            $display("FAIL basic_grant got %b want 00000110", fu_grant);
        end
        tick();
        fu_req = 8'h00;
        n_chk++;
        if (cdb_broadcast !== 4'b0011) begin
            n_fail++;
            $display("FAIL basic_bcast got %b want 0011", cdb_broadcast);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (pr_o[k] !== epr[k] || ar_o[k] !== ear[k]) begin
                n_fail++;
                $display("FAIL basic_tag%0d got %0d/%0d want %0d/%0d",
                         k, pr_o[k], ar_o[k], epr[k], ear[k]);
            end
        end
        n_chk++;
        if (dut.rr_ptr !== (RR ? 3'd3 : 3'd0)) begin
            n_fail++;
            $display("FAIL basic_rr got %0d want %0d",
                     dut.rr_ptr, RR ? 3 : 0);
        end
        tick();
        n_chk++;
        if (cdb_broadcast !== 4'b0000 || pr_o[0] !== 7'd0) begin
            n_fail++;
            $display("FAIL one_cycle got %b/%0d want 0000/0",
                     cdb_broadcast, pr_o[0]);
        end
        set_tags();
    endtask

    task automatic test_full_then_upper;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        fu_req = 8'hFF;
        #1;
        n_chk++;
        if (fu_grant !== 8'h0F) begin
            n_fail++;
            $display("FAIL ff_grant got %b want 00001111", fu_grant);
        end
        tick();
        fu_req = 8'hF0;
        n_chk++;
        if (cdb_broadcast !== 4'b1111 || dut.rr_ptr !== (RR ? 3'd4 : 3'd0)) begin
            n_fail++;
            $display("FAIL ff_bcast got %b rr %0d want 1111 rr %0d",
                     cdb_broadcast, dut.rr_ptr, RR ? 4 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (pr_o[k] !== 7'(100 + k) || ar_o[k] !== 5'(20 + k)) begin
                n_fail++;
                $display("FAIL ff_tag%0d got %0d/%0d want %0d/%0d",
                         k, pr_o[k], ar_o[k], 100 + k, 20 + k);
            end
        end
        #1;
        n_chk++;
        if (fu_grant !== 8'hF0) begin
            n_fail++;
            $display("FAIL f0_grant got %b want 11110000", fu_grant);
        end
        tick();
        fu_req = 8'h00;
        n_chk++;
        if (cdb_broadcast !== 4'b1111 || dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL f0_bcast got %b rr %0d want 1111 rr 0",
                     cdb_broadcast, dut.rr_ptr);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (pr_o[k] !== 7'(104 + k)) begin
                n_fail++;
                $display("FAIL f0_tag%0d got %0d want %0d",
                         k, pr_o[k], 104 + k);
            end
        end
        tick();
    endtask

    task automatic test_wrap;
        logic [6:0] epr [4];
        if (RR) epr = '{7'd106, 7'd107, 7'd100, 7'd101};
        else    epr = '{7'd100, 7'd101, 7'd106, 7'd107};
        fu_req = 8'b0010_0000;
        #1;
        n_chk++;
        if (fu_grant !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL fu5_grant got %b want 00100000", fu_grant);
        end
        tick();
        fu_req = 8'b1100_0011;
        n_chk++;
        if (dut.rr_ptr !== (RR ? 3'd6 : 3'd0) || pr_o[0] !== 7'd105) begin
            n_fail++;
            $display("FAIL fu5_rr got %0d tag %0d want %0d tag 105",
                     dut.rr_ptr, pr_o[0], RR ? 6 : 0);
        end
        #1;
        n_chk++;
        if (fu_grant !== 8'b1100_0011) begin
            n_fail++;
            $display("FAIL wrap_grant got %b want 11000011", fu_grant);
        end
        tick();
        fu_req = 8'h00;
        n_chk++;
        if (cdb_broadcast !== 4'b1111 || dut.rr_ptr !== (RR ? 3'd2 : 3'd0)) begin
            n_fail++;
            $display("FAIL wrap_bcast got %b rr %0d want 1111 rr %0d",
                     cdb_broadcast, dut.rr_ptr, RR ? 2 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (pr_o[k] !== epr[k]) begin
                n_fail++;
                $display("FAIL wrap_tag%0d got %0d want %0d",
                         k, pr_o[k], epr[k]);
            end
        end
        tick();
    endtask

    task automatic test_recover;
        logic [2:0] erp;
        erp     = RR ? 3'd2 : 3'd0;
        fu_req  = 8'hFF;
        recover = 1'b1;
        #1;
        n_chk++;
        if (fu_grant !== 8'h00) begin
            n_fail++;
            $display("FAIL rec_grant got %b want 00000000", fu_grant);
        end
        tick();
        recover = 1'b0;
        fu_req  = 8'h00;
        n_chk++;
        if (cdb_broadcast !== 4'b0000 || pr_o[0] !== 7'd0 ||
            dut.rr_ptr !== erp) begin
            n_fail++;
            $display("FAIL rec_out got %b/%0d rr %0d want 0000/0 rr %0d",
                     cdb_broadcast, pr_o[0], dut.rr_ptr, erp);
        end
        #1;
        n_chk++;
        if (fu_grant !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_grant got %b want 00000000", fu_grant);
        end
        tick();
        n_chk++;
        if (cdb_broadcast !== 4'b0000 || ar_o[3] !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_out got %b/%0d want 0000/0",
                     cdb_broadcast, ar_o[3]);
        end
    endtask

    task automatic test_reset_mid;
        fu_req = 8'hFF;
        #1;
        n_chk++;
        if (fu_grant !== (RR ? 8'h3C : 8'h0F)) begin
            n_fail++;
            $display("FAIL mid_grant got %b want %b",
                     fu_grant, RR ? 8'h3C : 8'h0F);
        end
        tick();
        reset = 1'b1;
        #1;
        n_chk++;
        if (fu_grant !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst_grant got %b want 00000000", fu_grant);
        end
        tick();
        reset  = 1'b0;
        fu_req = 8'h00;
        n_chk++;
        if (cdb_broadcast !== 4'b0000 || pr_o[1] !== 7'd0 ||
            dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_rst_out got %b/%0d rr %0d want 0000/0 rr 0",
                     cdb_broadcast, pr_o[1], dut.rr_ptr);
        end
    endtask

    task automatic test_partial;
        logic [6:0] epr [4];
        epr    = '{7'd101, 7'd103, 7'd107, 7'd0};
        fu_req = 8'b1000_1010;
        #1;
        n_chk++;
        if (fu_grant !== 8'b1000_1010) begin
            n_fail++;
            $display("FAIL part_grant got %b want 10001010", fu_grant);
        end
        tick();
        fu_req = 8'h00;
        n_chk++;
        if (cdb_broadcast !== 4'b0111 || dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL part_bcast got %b rr %0d want 0111 rr 0",
                     cdb_broadcast, dut.rr_ptr);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (pr_o[k] !== epr[k]) begin
                n_fail++;
                $display("FAIL part_tag%0d got %0d want %0d",
                         k, pr_o[k], epr[k]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] eg [3];
        if (RR) eg = '{8'h0F, 8'hF0, 8'h0F};
        else    eg = '{8'h0F, 8'h0F, 8'h0F};
        fu_req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (fu_grant !== eg[c]) begin
                n_fail++;
                $display("FAIL b2b_grant%0d got %b want %b",
                         c, fu_grant, eg[c]);
            end
            tick();
            n_chk++;
            if (cdb_broadcast !== 4'b1111) begin
                n_fail++;
                $display("FAIL b2b_bcast%0d got %b want 1111",
                         c, cdb_broadcast);
            end
        end
        fu_req = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_then_upper();
        test_wrap();
        test_recover();
        test_reset_mid();
        test_partial();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arb.md
CDB_ARB -- requirements
Module: cdb_arb

Interface
REQ-001 SHALL provide ports, clock and reset first:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- recover  in  1  branch-mispredict squash; suppresses grants this cycle
- fu_req  in  8  bit i = functional unit i has a completed result
- fu_pr_tags  in  56  FU i destination physical register at bits [7i+6:7i]
- fu_ar_tags  in  40  FU i destination architectural register at bits [5i+4:5i]
- fu_grant  out  8  bit i = FU i won a CDB slot this cycle (combinational)
- cdb_broadcast  out  `CDB_WIDTH (4)  bit k = CDB slot k valid (registered)
- cdb_pr_tag0..3  out  7 each  physical tag on slot k (registered)
- cdb_ar_tag0..3  out  5 each  architectural tag on slot k (registered)
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL keep a 3-bit round-robin pointer rr_ptr naming the highest-priority FU.
REQ-004 SHALL scan FUs in order rr_ptr, rr_ptr+1, ... mod 8 and grant the first min(4, popcount(fu_req)) requesters.
REQ-005 fu_grant SHALL be combinational from fu_req, rr_ptr, recover, reset; fu_grant SHALL be a subset of fu_req.
REQ-006 SHALL assign the k-th granted FU in scan order to CDB slot k (k = 0..3).
REQ-007 On the next rising edge, cdb_broadcast SHALL hold a contiguous low mask (0000, 0001, 0011, 0111 or 1111) matching the grant count; one-cycle latency from grant to broadcast.
REQ-008 Tags of occupied slots SHALL be the granted FU's fu_pr_tags/fu_ar_tags slices sampled at that edge; tags of unoccupied slots SHALL be 0.
REQ-009 Each broadcast SHALL last exactly one cycle; with no grants cdb_broadcast SHALL be 0 on the next cycle.
REQ-010 Handshake: requester SHALL hold fu_req and tags stable until it sees fu_grant; it drops fu_req the cycle after grant unless it has a new result.
REQ-011 If at least one grant, rr_ptr SHALL update to (index of last granted FU + 1) mod 8; with no grants rr_ptr SHALL hold.
REQ-012 Wrap-around: scan SHALL continue past FU7 to FU0 without gap.
REQ-013 recover=1 SHALL force fu_grant=0, load cdb_broadcast=0 and tags=0 at the edge, and hold rr_ptr.
REQ-014 A given FU SHALL never be granted more than one slot per cycle.

Reset
REQ-015 While reset=1: fu_grant=0; at the edge rr_ptr<=0, cdb_broadcast<=0, all cdb tags<=0.
REQ-016 reset SHALL take priority over recover and fu_req; requests pending at reset SHALL be dropped, not broadcast.

Configuration
REQ-017 Macro CDB_ARB_RR_EN: defined -> round-robin per REQ-011; undefined -> fixed priority, rr_ptr constant 0 (FU0 highest, FU7 lowest), all other requirements unchanged.

Verification
REQ-018 Bench SHALL cover (CDB_ARB_RR_EN defined unless stated):
- After reset, fu_req=8'b0000_0110, pr tags FU1=33, FU2=40 -> fu_grant=0000_0110; next cycle cdb_broadcast=0011, pr_tag0=33, pr_tag1=40, rr_ptr=3.
- rr_ptr=0, fu_req=8'hFF -> grant 0000_1111; next cycle fu_req=8'hF0 -> grant 1111_0000, rr_ptr=0 after.
- rr_ptr=6, fu_req=1100_0011 -> grant all four; slot order FU6,FU7,FU0,FU1; rr_ptr=2.
- fu_req=8'hFF with recover=1 -> fu_grant=0, next-cycle cdb_broadcast=0, rr_ptr unchanged; fu_req=0 -> broadcast 0, tags 0.
- Reset asserted mid-stream with fu_req=8'hFF -> no grants, outputs 0, rr_ptr=0 next cycle.
- Macro undefined, fu_req=8'hFF for 3 cycles -> grant 0000_1111 every cycle.
